// File: rtl/prv664_commit_monitor.sv
// ============================================================================
// prv664_commit_monitor: commit-stream monitor with shadow regfile, counters,
// good-trap pass/fail detection and a commit-free watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 64
`endif

module prv664_commit_monitor #(
  parameter int XLEN           = `XLEN,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic            clk_i,
  input  logic            arst_ni,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic            commit_trap_i,
  input  logic            commit_wen_i,
  input  logic [4:0]      commit_windex_i,
  input  logic [XLEN-1:0] commit_wdata_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  input  logic [4:0]      rd_index_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic [1:0]      state_o,
  output logic            done_o,
  output logic [63:0]     instret_o,
  output logic [63:0]     cycle_o,
  output logic [XLEN-1:0] last_pc_o,
  output logic [XLEN-1:0] trap_code_o,
  output logic [XLEN-1:0] trap_mepc_o
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      state_q,     state_d;
  logic [WD_W-1:0] wd_q,        wd_d;
  logic [63:0]     instret_q,   instret_d;
  logic [63:0]     cycle_q,     cycle_d;
  logic [XLEN-1:0] last_pc_q,   last_pc_d;
  logic [XLEN-1:0] trap_code_q, trap_code_d;
  logic [XLEN-1:0] trap_mepc_q, trap_mepc_d;
  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];

  logic            accept;
  logic            reg_we;
  logic            wd_expire;
  logic [XLEN-1:0] eff_a0;

  assign accept    = commit_valid_i && (state_q == ST_RUN);
  assign reg_we    = accept && commit_wen_i && (commit_windex_i != 5'd0);
  assign wd_expire = (state_q == ST_RUN) && !accept && (wd_q == WD_LAST);
  // a0 seen by the trap includes the trap instruction's own writeback to x10
  assign eff_a0    = (commit_wen_i && (commit_windex_i == 5'd10)) ? commit_wdata_i
                                                                  : regs_q[10];

  // State register
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; PASS/FAIL/TIMEOUT are terminal
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (accept && commit_trap_i) begin
          state_d = (eff_a0 == '0) ? ST_PASS : ST_FAIL;
        end else if (wd_expire) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Output logic
  always_comb begin
    state_o = state_q;
    done_o  = (state_q != ST_RUN);
  end

  always_comb begin
    wd_d        = wd_q;
    instret_d   = instret_q;
    cycle_d     = cycle_q;
    last_pc_d   = last_pc_q;
    trap_code_d = trap_code_q;
    trap_mepc_d = trap_mepc_q;
    regs_d      = regs_q;
    if (state_q == ST_RUN) begin
      cycle_d = cycle_q + 64'd1;
      wd_d    = accept ? '0 : wd_q + 1'b1;
    end
    if (accept) begin
      instret_d = instret_q + 64'd1;
      last_pc_d = commit_pc_i;
      if (commit_trap_i) begin
        trap_code_d = eff_a0;
        trap_mepc_d = csr_mepc_i;
      end
    end
    if (reg_we) begin
      regs_d[commit_windex_i] = commit_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wd_q        <= '0;
      instret_q   <= '0;
      cycle_q     <= '0;
      last_pc_q   <= '0;
      trap_code_q <= '0;
      trap_mepc_q <= '0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wd_q        <= wd_d;
      instret_q   <= instret_d;
      cycle_q     <= cycle_d;
      last_pc_q   <= last_pc_d;
      trap_code_q <= trap_code_d;
      trap_mepc_q <= trap_mepc_d;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // No bypass: reads always return the registered contents
  assign rd_data_o   = (rd_index_i == 5'd0) ? '0 : regs_q[rd_index_i];
  assign instret_o   = instret_q;
  assign cycle_o     = cycle_q;
  assign last_pc_o   = last_pc_q;
  assign trap_code_o = trap_code_q;
  assign trap_mepc_o = trap_mepc_q;

endmodule

`default_nettype wire

// File: tb/tb_prv664_commit_monitor.sv
// ============================================================================
// tb_prv664_commit_monitor: scoreboard bench with a behavioural reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_prv664_commit_monitor;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_valid = 1'b0, c_trap = 1'b0, c_wen = 1'b0;
  logic [63:0] c_pc = '0, c_wdata = '0, c_mepc = '0;
  logic [4:0]  c_idx = '0, rd_idx = '0;
  logic [63:0] rd_data, instret, cycle, last_pc, trap_code, trap_mepc;
  logic [1:0]  state;
  logic        done;

  prv664_commit_monitor #(.XLEN(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .arst_ni(rst_n),
    .commit_valid_i(c_valid), .commit_pc_i(c_pc), .commit_trap_i(c_trap),
    .commit_wen_i(c_wen), .commit_windex_i(c_idx), .commit_wdata_i(c_wdata),
    .csr_mepc_i(c_mepc), .rd_index_i(rd_idx), .rd_data_o(rd_data),
    .state_o(state), .done_o(done), .instret_o(instret), .cycle_o(cycle),
    .last_pc_o(last_pc), .trap_code_o(trap_code), .trap_mepc_o(trap_mepc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [63:0] instret, cycle, last_pc, code, mepc, rd;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: architectural view of the monitor
  int          m_state;
  int          m_silent;
  logic [63:0] m_regs [32];
  logic [63:0] m_instret, m_cycle, m_last_pc, m_code, m_mepc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_silent = 0;
    m_instret = 0; m_cycle = 0; m_last_pc = 0; m_code = 0; m_mepc = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
  endtask

  task automatic model_edge(input logic v, input logic [63:0] pc, input logic tr,
                            input logic we, input logic [4:0] idx,
                            input logic [63:0] wd, input logic [63:0] mepc);
    logic [63:0] a0;
    if (m_state != 0) return;
    m_cycle++;
    if (v) begin
      m_instret++;
      m_last_pc = pc;
      m_silent  = 0;
      if (tr) begin
        a0      = (we && idx == 5'd10) ? wd : m_regs[10];
        m_state = (a0 == 0) ? 1 : 2;
        m_code  = a0;
        m_mepc  = mepc;
      end
      if (we && idx != 0) m_regs[idx] = wd;
    end else begin
      m_silent++;
      if (m_silent == TO) m_state = 3;
    end
  endtask

  // Drive one cycle at the falling edge and queue the expected post-edge view
  task automatic cyc(input logic v, input logic [63:0] pc, input logic tr,
                     input logic we, input logic [4:0] idx, input logic [63:0] wd,
                     input logic [63:0] mepc, input logic [4:0] ri);
    exp_t e;
    @(negedge clk);
    c_valid = v; c_pc = pc; c_trap = tr; c_wen = we; c_idx = idx;
    c_wdata = wd; c_mepc = mepc; rd_idx = ri;
    model_edge(v, pc, tr, we, idx, wd, mepc);
    e.st = 2'(m_state); e.instret = m_instret; e.cycle = m_cycle;
    e.last_pc = m_last_pc; e.code = m_code; e.mepc = m_mepc;
    e.rd = (ri == 0) ? 64'd0 : m_regs[ri];
    q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [4:0] ri);
    for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, ri);
  endtask

  // Asynchronous reset, checked before any clock edge can occur
  task automatic do_reset();
    @(posedge clk);
    #3;
    chk("queue_drained", 64'(q.size()), 64'd0);
    c_valid = 0; c_trap = 0; c_wen = 0; rd_idx = 5'd10;
    rst_n = 1'b0;
    #1;
    chk("rst_state", {62'd0, state}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_cycle", cycle, 64'd0);
    chk("rst_last_pc", last_pc, 64'd0);
    chk("rst_trap_code", trap_code, 64'd0);
    chk("rst_trap_mepc", trap_mepc, 64'd0);
    chk("rst_rd_x10", rd_data, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compares every post-edge output against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", {62'd0, state}, {62'd0, e.st});
        chk("done", {63'd0, done}, {63'd0, (e.st != 2'd0)});
        chk("instret", instret, e.instret);
        chk("cycle", cycle, e.cycle);
        chk("last_pc", last_pc, e.last_pc);
        chk("trap_code", trap_code, e.code);
        chk("trap_mepc", trap_mepc, e.mepc);
        chk("rd_data", rd_data, e.rd);
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // x5 write, then discarded x0 write
    cyc(1, 64'h100, 0, 1, 5'd5, 64'h1234, 0, 5'd5);
    cyc(1, 64'h104, 0, 1, 5'd0, 64'hFFFF, 0, 5'd0);
    idle(1, 5'd5);
    idle(1, 5'd0);

    // Good trap: x10 = 0 then trap -> PASS; later commits ignored
    do_reset();
    cyc(1, 64'h80000000, 0, 1, 5'd10, 64'd0, 0, 5'd10);
    cyc(1, 64'h80000100, 1, 0, 5'd0, 64'd0, 64'h80000040, 5'd10);
    cyc(1, 64'h80000104, 0, 1, 5'd7, 64'h55, 0, 5'd7);
    cyc(1, 64'h80000108, 1, 1, 5'd10, 64'h9, 0, 5'd10);
    idle(TO + 2, 5'd7);

    // Trap that writes x10=3 itself -> FAIL
    do_reset();
    cyc(1, 64'h200, 1, 1, 5'd10, 64'd3, 64'h1C0, 5'd10);
    idle(3, 5'd10);

    // Async reset after FAIL, then a0=0 trap -> PASS
    do_reset();
    cyc(1, 64'h300, 1, 0, 5'd0, 64'd0, 64'h2C0, 5'd10);
    idle(2, 5'd0);

    // Watchdog: restart at 15 idle edges, then expire at exactly 16
    do_reset();
    cyc(1, 64'h400, 0, 0, 5'd0, 64'd0, 0, 5'd0);
    idle(TO - 1, 5'd0);
    cyc(1, 64'h404, 0, 0, 5'd0, 64'd0, 0, 5'd0);
    idle(TO + 3, 5'd0);

    // 1000 back-to-back random commits, then read back the whole file
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      cyc(1, 64'h1000 + 64'(i * 4), 0, 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), {$urandom, $urandom}, 0,
          5'($urandom_range(0, 31)));
    end
    for (int r = 0; r < 32; r++) idle(1, 5'(r));

    // Random traffic with sparse commits and occasional traps
    for (int k = 0; k < 4; k++) begin
      do_reset();
      for (int i = 0; i < 200; i++) begin
        cyc(1'($urandom_range(0, 3) != 0), {32'd0, $urandom},
            1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(8, 12)), 64'($urandom_range(0, 2)),
            {32'd0, $urandom}, 5'($urandom_range(0, 31)));
      end
    end

    @(posedge clk);
    #3;
    chk("final_queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prv664_commit_monitor.md
# prv664_commit_monitor

Simulation-only consumer of the core's per-instruction commit stream and its mepc CSR export. It tracks retired-instruction and cycle counts, maintains a shadow integer register file from committed writebacks, and runs a watchdog. It decides test outcome by the good-trap convention: on a trap commit, a0 (x10) == 0 means PASS, anything else means FAIL. It sits in the simulation top beside the core and drives the bench's end-of-test and difftest logic.

## Interface
Parameters:
- XLEN, `XLEN (64): data/PC width.
- TIMEOUT_CYCLES, 100000: number of consecutive commit-free cycles that triggers TIMEOUT; must be ≥ 2.

Ports:
- clk_i  in  1  core clock.
- arst_ni  in  1  reset; asynchronous, active-low.
- commit_valid_i  in  1  one instruction retires this cycle.
- commit_pc_i  in  XLEN  PC of the retiring instruction.
- commit_trap_i  in  1  the retiring instruction is the end-of-test trap.
- commit_wen_i  in  1  the retiring instruction writes an int register.
- commit_windex_i  in  5  destination register index.
- commit_wdata_i  in  XLEN  writeback value.
- csr_mepc_i  in  XLEN  current mepc.
- rd_index_i  in  5  shadow-register read index.
- rd_data_o  out  XLEN  combinational shadow-register read; x0 reads 0.
- state_o  out  2  0=RUN, 1=PASS, 2=FAIL, 3=TIMEOUT.
- done_o  out  1  high when state_o != RUN.
- instret_o  out  64  retired-instruction count.
- cycle_o  out  64  cycles spent in RUN.
- last_pc_o  out  XLEN  PC of the most recent accepted commit.
- trap_code_o  out  XLEN  value of a0 latched at trap.
- trap_mepc_o  out  XLEN  csr_mepc_i latched at trap.

## Operation
- An accepted commit is `commit_valid_i` asserted while state is RUN. Once state leaves RUN, all commits are ignored.
- Shadow register file: 32 x XLEN. An accepted commit with `commit_wen_i` and `commit_windex_i` != 0 writes `commit_wdata_i`. Writes to x0 are discarded, and x0 always reads 0. Entries reset to 0.
- `instret_o` increments by 1 per accepted commit, including the trap commit. `cycle_o` increments on every clock edge while in RUN. Both are 64-bit and wrap modulo 2^64.
- `last_pc_o` loads `commit_pc_i` on every accepted commit.
- Watchdog counter:
  - Clears on every accepted commit.
  - Otherwise increments while in RUN.
  - When it would reach TIMEOUT_CYCLES, state moves to TIMEOUT.
- Trap handling, on an accepted commit with `commit_trap_i`:
  - The effective a0 is `commit_wdata_i` if the same commit writes x10; otherwise it is shadow x10.
  - Effective a0 == 0 → PASS; else → FAIL.
  - `trap_code_o` latches the effective a0 and `trap_mepc_o` latches `csr_mepc_i`.
  - The trap commit's own register write is still applied.
- FSM:
  - RUN → PASS/FAIL on a trap commit.
  - RUN → TIMEOUT on watchdog expiry.
  - PASS, FAIL and TIMEOUT are terminal until reset.
  - If a trap commit and watchdog expiry occur in the same cycle, the trap wins. In practice an accepted commit clears the watchdog, so expiry cannot fire that cycle.

## Timing
- Reset values (asynchronous):
  - state_o = RUN, done_o = 0.
  - instret_o, cycle_o, last_pc_o, trap_code_o, trap_mepc_o = 0.
  - Watchdog counter = 0; all shadow registers = 0.
- All outputs except rd_data_o are registered, with one-cycle latency. A commit in cycle N is visible in instret_o, last_pc_o and rd_data_o from cycle N+1. A trap commit in cycle N gives state_o and done_o in cycle N+1.
- rd_data_o is a combinational read of the registered array, with no write-through bypass of the current commit.
- Watchdog: with the last accepted commit at edge E, TIMEOUT is visible after edge E+TIMEOUT_CYCLES if no commit is accepted in between.
- cycle_o freezes at the value from the last RUN edge. The transition edge itself counts.
- Asserting reset mid-run clears everything immediately. Operation restarts in RUN on the first edge after deassertion.

## Test plan
- Write x5=0x1234 then x0=0xFFFF on consecutive cycles → rd_data_o(5)=0x1234, rd_data_o(0)=0, instret_o=2, last_pc_o=second PC.
- Set x10=0, then a trap commit at PC 0x80000100 with mepc=0x80000040 → state_o=PASS next cycle, trap_code_o=0, trap_mepc_o=0x80000040, instret_o=2. Further commits leave instret_o at 2.
- Trap commit that itself writes x10=3 while shadow x10=0 → FAIL, trap_code_o=3, rd_data_o(10)=3.
- TIMEOUT_CYCLES=16, one commit then silence → state_o=TIMEOUT exactly 16 edges after the commit edge. A commit at 15 edges of silence restarts the count with no timeout.
- Assert arst_ni asynchronously mid-stream after a FAIL → all outputs return to reset values without waiting for a clock edge. The next trap with a0=0 yields PASS.
- 1000 back-to-back commits with random wen/index/data → shadow file matches the bench's reference model, and instret_o=1000.
